// File: rtl/pwm_sigma_delta_out_if.sv
// Sample/enable in, PWM pin drive and period strobe out, for one pwm_sigma_delta_out channel.
interface pwm_sigma_delta_out_if #(
  parameter int DW = 14
);
  logic [DW-1:0] dat_i;
  logic          en_i;
  logic          pwm_o;
  logic          period_o;

  modport master (output dat_i, en_i, input pwm_o, period_o);
  modport slave  (input dat_i, en_i, output pwm_o, period_o);
endinterface

// File: rtl/pwm_sigma_delta_out.sv
// Signed sample -> 1-bit PWM: coarse duty from the MSBs each period, LSBs dithered
// across 2**(DW-CW) periods by a first-order sigma-delta accumulator.
module pwm_sigma_delta_out #(
  parameter int DW     = 14,
  parameter int CW     = 8,
  parameter int INVERT = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  pwm_sigma_delta_out_if.slave    bus
);
  localparam int   FW  = DW - CW;
  localparam logic INV = (INVERT != 0);

  logic [CW-1:0] cnt;
  logic [CW:0]   duty;
  logic [FW-1:0] acc;

  logic [DW-1:0] u;
  logic [CW-1:0] hi;
  logic [FW-1:0] frac;
  logic [FW:0]   sum;
  logic [CW:0]   duty_next;
  logic          load;

  // Offset binary: flipping the sign bit maps -2**(DW-1)..2**(DW-1)-1 onto 0..2**DW-1.
  assign u         = {~bus.dat_i[DW-1], bus.dat_i[DW-2:0]};
  assign hi        = u[DW-1:FW];
  assign frac      = u[FW-1:0];
  assign sum       = {1'b0, acc} + {1'b0, frac};
  assign duty_next = {1'b0, hi} + {{CW{1'b0}}, sum[FW]};
  assign load      = bus.en_i & (cnt == '1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt          <= '1;
      duty         <= '0;
      acc          <= '0;
      bus.pwm_o    <= INV;
      bus.period_o <= 1'b0;
    end else begin
      // Outputs come from the present cnt/duty, so duty updates only show up after the wrap.
      bus.pwm_o    <= INV ^ (bus.en_i & ({1'b0, cnt} < duty));
      bus.period_o <= bus.en_i & (cnt == '0);
      if (!bus.en_i) begin
        cnt <= '1;
        acc <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (load) begin
          duty <= duty_next;
          acc  <= sum[FW-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_sigma_delta_out.sv
// Bench for pwm_sigma_delta_out: normal and inverted instances share one stimulus,
// checked every cycle against a period-level arithmetic reference.
module tb_pwm_sigma_delta_out;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int   cur_dat = 0;

  int checks   = 0;
  int failures = 0;

  // Reference: position within period, duty of the running period, fractional residue.
  int   m_pos = 255;
  int   m_duty = 0;
  int   m_res = 0;
  logic e_pwm = 1'b0;
  logic e_per = 1'b0;

  always #5 clk = ~clk;

  pwm_sigma_delta_out_if #(.DW(14)) ifa ();
  pwm_sigma_delta_out_if #(.DW(14)) ifb ();

  pwm_sigma_delta_out #(.DW(14), .CW(8), .INVERT(0)) u_dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  pwm_sigma_delta_out #(.DW(14), .CW(8), .INVERT(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input int d);
    logic [31:0] dv;
    dv         = d;
    rst        = r;
    en         = e;
    cur_dat    = d;
    ifa.dat_i  = dv[13:0];
    ifb.dat_i  = dv[13:0];
    ifa.en_i   = e;
    ifb.en_i   = e;
  endtask

  task automatic step();
    int uu;
    @(posedge clk);
    if (rst) begin
      m_pos = 255; m_duty = 0; m_res = 0; e_pwm = 1'b0; e_per = 1'b0;
    end else begin
      e_pwm = en && (m_pos < m_duty);
      e_per = en && (m_pos == 0);
      if (!en) begin
        m_pos = 255;
        m_res = 0;
      end else begin
        if (m_pos == 255) begin
          uu     = cur_dat + 8192;
          m_res  = m_res + uu % 64;
          m_duty = uu / 64 + ((m_res >= 64) ? 1 : 0);
          m_res  = m_res % 64;
        end
        m_pos = (m_pos + 1) % 256;
      end
    end
    #1;
    chk("pwm", ifa.pwm_o, e_pwm);
    chk("pwm_inv", ifb.pwm_o, !e_pwm);
    chk("period", ifa.period_o, e_per);
    chk("period_inv", ifb.period_o, e_per);
  endtask

  // Restart from a disabled state, then count active cycles over nper whole periods.
  task automatic run_count(input string tag, input int d, input int nper, input int exp_active);
    int act, act_inv, pers;
    drive(1'b0, 1'b0, d);
    step();
    drive(1'b0, 1'b1, d);
    step();
    act = 0; act_inv = 0; pers = 0;
    for (int i = 0; i < nper * 256; i++) begin
      step();
      act     += int'(ifa.pwm_o);
      act_inv += int'(!ifb.pwm_o);
      pers    += int'(ifa.period_o);
    end
    chk({tag, "_active"}, act, exp_active);
    chk({tag, "_active_inv"}, act_inv, exp_active);
    chk({tag, "_periods"}, pers, nper);
  endtask

  initial begin
    int act, d, len;
    drive(1'b1, 1'b0, 0);
    step();
    chk("reset_pwm", ifa.pwm_o, 1'b0);
    chk("reset_pwm_inv", ifb.pwm_o, 1'b1);
    chk("reset_period", ifa.period_o, 1'b0);
    step();

    run_count("t1_min", -8192, 2, 0);
    run_count("t2_zero", 0, 3, 384);
    run_count("t3_one", 1, 64, 8193);
    run_count("t4_max", 8191, 64, 16383);

    // Mid-period sample change: current period keeps 128, next one gets 192.
    drive(1'b0, 1'b0, 0);
    step();
    drive(1'b0, 1'b1, 0);
    step();
    act = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) drive(1'b0, 1'b1, 4096);
      step();
      act += int'(ifa.pwm_o);
    end
    chk("t5_old_period", act, 128);
    step();
    chk("t5_first_new", ifa.pwm_o, 1'b1);
    act = 1;
    for (int i = 1; i < 256; i++) begin
      step();
      act += int'(ifa.pwm_o);
    end
    chk("t5_new_period", act, 192);

    // Disable mid-period, re-enable, then reset mid-period.
    drive(1'b0, 1'b0, 4096);
    step();
    drive(1'b0, 1'b1, 4096);
    step();
    for (int i = 0; i < 50; i++) step();
    drive(1'b0, 1'b0, 4096);
    step();
    chk("t6_dis_pwm", ifa.pwm_o, 1'b0);
    chk("t6_dis_pwm_inv", ifb.pwm_o, 1'b1);
    chk("t6_dis_period", ifa.period_o, 1'b0);
    drive(1'b0, 1'b1, 4096);
    step();
    chk("t6_reen_no_strobe", ifa.period_o, 1'b0);
    step();
    chk("t6_reen_strobe", ifa.period_o, 1'b1);
    for (int i = 0; i < 30; i++) step();
    drive(1'b1, 1'b1, 4096);
    step();
    chk("t6_rst_pwm", ifa.pwm_o, 1'b0);
    chk("t6_rst_pwm_inv", ifb.pwm_o, 1'b1);
    chk("t6_rst_period", ifa.period_o, 1'b0);
    drive(1'b0, 1'b1, 4096);
    for (int i = 0; i < 300; i++) step();

    // Random constant sample over a full dither window.
    d = int'($urandom_range(16383, 0)) - 8192;
    run_count("rnd_window", d, 64, d + 8192);

    // Random segments with enable drops and reset pulses.
    for (int s = 0; s < 10; s++) begin
      d   = int'($urandom_range(16383, 0)) - 8192;
      len = int'($urandom_range(900, 200));
      drive(1'b0, 1'b1, d);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(199, 0) == 0) drive(1'b0, 1'b0, d);
        else if ($urandom_range(499, 0) == 0) drive(1'b1, 1'b1, d);
        else if ($urandom_range(63, 0) == 0)
          drive(1'b0, 1'b1, int'($urandom_range(16383, 0)) - 8192);
        else drive(1'b0, 1'b1, cur_dat);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
